// File: rtl/mst_fifo_arbiter_if.sv
// -----------------------------------------------------------------------------
// mst_fifo_arbiter_if
//   Bundle of the request/grant handshakes of the two TLP sources, the shared
//   PCIe master write FIFO port and the arbiter status outputs.
//
//   req0/req1       request, held from request until EOP is accepted
//   gnt0/gnt1       grant, registered, one-hot or zero
//   din0/din1       18-bit requester words in master-FIFO format
//   wr_en0/wr_en1   requester word valid
//   full0/full1     per-requester back-pressure
//   mst_din         word to the master FIFO
//   mst_wr_en       write strobe to the master FIFO
//   mst_full        master FIFO almost-full
//   timeout_err     one-cycle pulse on forced release
//   pkt_cnt0/1      packets forwarded per port
//
//   Modport master: the arbiter. Modport slave: requesters and master FIFO.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface mst_fifo_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             req0;
    logic             req1;
    logic             gnt0;
    logic             gnt1;
    logic [17:0]      din0;
    logic [17:0]      din1;
    logic             wr_en0;
    logic             wr_en1;
    logic             full0;
    logic             full1;
    logic [17:0]      mst_din;
    logic             mst_wr_en;
    logic             mst_full;
    logic             timeout_err;
    logic [CNT_W-1:0] pkt_cnt0;
    logic [CNT_W-1:0] pkt_cnt1;

    modport master (
        input  req0, req1, din0, din1, wr_en0, wr_en1, mst_full,
        output gnt0, gnt1, full0, full1, mst_din, mst_wr_en, timeout_err,
               pkt_cnt0, pkt_cnt1
    );

    modport slave (
        output req0, req1, din0, din1, wr_en0, wr_en1, mst_full,
        input  gnt0, gnt1, full0, full1, mst_din, mst_wr_en, timeout_err,
               pkt_cnt0, pkt_cnt1
    );
endinterface

// File: rtl/mst_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// mst_fifo_arbiter
//   Packet-granular arbiter sharing the single PCIe master write FIFO between
//   port 0 (RX DMA receiver) and port 1 (TX status/completion writer). One
//   port is granted at a time; its words are forwarded unmodified through one
//   register stage and the grant is released on an accepted EOP word
//   (din[17:16] == 2'b01). Ties are resolved round-robin; a stall watchdog and
//   a request-drop check force release of a hung requester.
//
//   Build option: define MST_ARB_PRIO0_EN for fixed priority (port 0 wins
//   every tie); otherwise round-robin.
//
//   Ports
//     sys_clk     system clock
//     sys_rst_n   asynchronous active-low reset
//     bus         mst_fifo_arbiter_if.master (handshakes, FIFO port, status)
//
//   Parameters
//     TIMEOUT     cycles without an accepted word before forced release
//                 (1..65535)
//     CNT_W       width of the per-port packet counters
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mst_fifo_arbiter #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input logic                sys_clk,
    input logic                sys_rst_n,
    mst_fifo_arbiter_if.master bus
);
    localparam int WD_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    arb_state_t       state;
    logic             last;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             err_q;
    logic [WD_W-1:0]  wd_cnt;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic [17:0]      din_p1;
    logic             vld_p1;

    // Signals of whichever port currently owns the grant.
    logic        own_req;
    logic        own_wr;
    logic [17:0] own_din;
    logic        own_eop;
    logic        wd_fire;
    logic        pick1;

    always_comb begin
        own_req = 1'b0;
        own_wr  = 1'b0;
        own_din = '0;
        if (state == ARB_GNT0) begin
            own_req = bus.req0;
            own_wr  = bus.wr_en0;
            own_din = bus.din0;
        end else if (state == ARB_GNT1) begin
            own_req = bus.req1;
            own_wr  = bus.wr_en1;
            own_din = bus.din1;
        end
    end

    assign own_eop = (own_din[17:16] == 2'b01);

    // wd_cnt holds the number of preceding cycles without an accepted word;
    // this cycle is the TIMEOUT-th one, so release regardless of wr_en
    // (a word offered now is discarded).
    assign wd_fire = (wd_cnt == WD_W'(TIMEOUT - 1));

`ifdef MST_ARB_PRIO0_EN
    assign pick1 = bus.req1 & ~bus.req0;
`else
    // last == 1 means port 1 was served most recently, so port 0 wins a tie.
    assign pick1 = bus.req1 & (~bus.req0 | ~last);
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= ARB_IDLE;
            last   <= 1'b1;
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            err_q  <= 1'b0;
            wd_cnt <= '0;
            cnt0   <= '0;
            cnt1   <= '0;
            din_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    wd_cnt <= '0;
                    if (bus.req0 | bus.req1) begin
                        state  <= pick1 ? ARB_GNT1 : ARB_GNT0;
                        gnt0_q <= ~pick1;
                        gnt1_q <= pick1;
                    end
                end
                default: begin
                    if (!own_req || wd_fire) begin
                        // Forced release: requester gave up or hung.
                        state  <= ARB_IDLE;
                        gnt0_q <= 1'b0;
                        gnt1_q <= 1'b0;
                        err_q  <= 1'b1;
                        last   <= (state == ARB_GNT1);
                    end else if (own_wr) begin
                        // stage p0 -> p1: accepted word registered toward master FIFO
                        din_p1 <= own_din;
                        vld_p1 <= 1'b1;
                        wd_cnt <= '0;
                        if (own_eop) begin
                            state  <= ARB_IDLE;
                            gnt0_q <= 1'b0;
                            gnt1_q <= 1'b0;
                            last   <= (state == ARB_GNT1);
                            if (state == ARB_GNT1) begin
                                cnt1 <= cnt1 + 1'b1;
                            end else begin
                                cnt0 <= cnt0 + 1'b1;
                            end
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.gnt0        = gnt0_q;
    assign bus.gnt1        = gnt1_q;
    assign bus.full0       = bus.mst_full | ~gnt0_q;
    assign bus.full1       = bus.mst_full | ~gnt1_q;
    assign bus.mst_din     = din_p1;
    assign bus.mst_wr_en   = vld_p1;
    assign bus.timeout_err = err_q;
    assign bus.pkt_cnt0    = cnt0;
    assign bus.pkt_cnt1    = cnt1;
endmodule

// File: tb/tb_mst_fifo_arbiter.sv
`timescale 1ns/1ps
module tb_mst_fifo_arbiter;
    localparam int TO = 8;
    localparam int CW = 16;
`ifdef MST_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    logic sys_clk;
    logic sys_rst_n;

    mst_fifo_arbiter_if #(.CNT_W(CW)) bus();

    mst_fifo_arbiter #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: who owns the FIFO, how long the owner has been
    // silent, who was served last, and what the FIFO should see.
    int          m_owner;
    int          m_quiet;
    int          m_last;
    bit          m_wr;
    bit          m_err;
    logic [17:0] m_din;
    logic [CW-1:0] m_cnt[2];
    bit          m_rq[2];
    bit          m_we[2];
    logic [17:0] m_dd[2];

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_owner = -1;
            m_quiet = 0;
            m_last  = 1;
            m_wr    = 1'b0;
            m_err   = 1'b0;
            m_din   = '0;
            m_cnt[0] = '0;
            m_cnt[1] = '0;
        end else begin
            m_rq[0] = bus.req0;   m_rq[1] = bus.req1;
            m_we[0] = bus.wr_en0; m_we[1] = bus.wr_en1;
            m_dd[0] = bus.din0;   m_dd[1] = bus.din1;
            m_wr  = 1'b0;
            m_err = 1'b0;
            if (m_owner < 0) begin
                m_quiet = 0;
                if (m_rq[0] && m_rq[1])
                    m_owner = PRIO0 ? 0 : (m_last == 1 ? 0 : 1);
                else if (m_rq[0])
                    m_owner = 0;
                else if (m_rq[1])
                    m_owner = 1;
            end else if (!m_rq[m_owner] || m_quiet == TO - 1) begin
                m_err   = 1'b1;
                m_last  = m_owner;
                m_owner = -1;
            end else if (m_we[m_owner]) begin
                m_wr    = 1'b1;
                m_din   = m_dd[m_owner];
                m_quiet = 0;
                if (m_dd[m_owner][17:16] == 2'b01) begin
                    m_cnt[m_owner] = m_cnt[m_owner] + 1'b1;
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else begin
                m_quiet++;
            end
        end
    end

    always @(negedge sys_clk) begin
        chk("gnt0", 32'(bus.gnt0), 32'(m_owner == 0));
        chk("gnt1", 32'(bus.gnt1), 32'(m_owner == 1));
        chk("mst_wr_en", 32'(bus.mst_wr_en), 32'(m_wr));
        chk("mst_din", 32'(bus.mst_din), 32'(m_din));
        chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
        chk("pkt_cnt0", 32'(bus.pkt_cnt0), 32'(m_cnt[0]));
        chk("pkt_cnt1", 32'(bus.pkt_cnt1), 32'(m_cnt[1]));
        chk("full0", 32'(bus.full0), 32'(bus.mst_full | (m_owner != 0)));
        chk("full1", 32'(bus.full1), 32'(bus.mst_full | (m_owner != 1)));
    end

    logic [17:0] seen[$];
    always @(negedge sys_clk) begin
        if (bus.mst_wr_en) seen.push_back(bus.mst_din);
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic set_port(input int p, input bit rq, input bit we, input logic [17:0] d);
        if (p == 0) begin
            bus.req0 = rq; bus.wr_en0 = we; bus.din0 = d;
        end else begin
            bus.req1 = rq; bus.wr_en1 = we; bus.din1 = d;
        end
    endtask

    function automatic bit gnt_of(input int p);
        return (p == 0) ? bus.gnt0 : bus.gnt1;
    endfunction

    task automatic wait_gnt(input int p, input string nm);
        int n;
        n = 0;
        while (!gnt_of(p) && n < 20) begin
            tick();
            n++;
        end
        chk(nm, 32'(gnt_of(p)), 32'd1);
    endtask

    task automatic finish_pkt(input int p, input logic [17:0] w);
        wait_gnt(p, "finish_gnt");
        set_port(p, 1'b1, 1'b1, w);
        tick();
        set_port(p, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        set_port(0, 1'b0, 1'b0, '0);
        set_port(1, 1'b0, 1'b0, '0);
        bus.mst_full = 1'b0;
        sys_rst_n = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [17:0] rword(input int p, input int i, input int n, input int id);
        logic [1:0] tag;
        tag = (i == n - 1) ? 2'b01 : ((i == 0) ? 2'b10 : 2'b00);
        return {tag, 4'(p), 12'(id * 8 + i)};
    endfunction

    logic [17:0] t1w[4];
    logic [17:0] t3w[4];
    bit  act[2];
    int  len[2];
    int  idx[2];
    int  pid[2];
    int  stall[2];
    bit  pwe[2];
    bit  pgnt[2];
    int  seq;
    int  w;
    bit  we;
    bit  fl;

    initial begin
        t1w[0] = 18'h2A000; t1w[1] = 18'h00012; t1w[2] = 18'h03450; t1w[3] = 18'h10001;
        t3w[0] = 18'h2B001; t3w[1] = 18'h00002; t3w[2] = 18'h00003; t3w[3] = 18'h10004;
        sys_rst_n = 1'b0;
        set_port(0, 1'b0, 1'b0, '0);
        set_port(1, 1'b0, 1'b0, '0);
        bus.mst_full = 1'b0;
        #1;
        do_reset();

        // reset values
        chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
        chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
        chk("rst_mst_wr_en", 32'(bus.mst_wr_en), 32'd0);
        chk("rst_mst_din", 32'(bus.mst_din), 32'd0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("rst_pkt_cnt0", 32'(bus.pkt_cnt0), 32'd0);
        chk("rst_full0", 32'(bus.full0), 32'd1);

        // 1: single requester, four-word packet
        set_port(0, 1'b1, 1'b0, '0);
        tick();
        chk("t1_gnt0", 32'(bus.gnt0), 32'd1);
        for (int i = 0; i < 4; i++) begin
            set_port(0, 1'b1, 1'b1, t1w[i]);
            tick();
            chk("t1_wr_en", 32'(bus.mst_wr_en), 32'd1);
            chk("t1_din", 32'(bus.mst_din), 32'(t1w[i]));
        end
        set_port(0, 1'b0, 1'b0, '0);
        chk("t1_gnt0_low", 32'(bus.gnt0), 32'd0);
        chk("t1_pkt_cnt0", 32'(bus.pkt_cnt0), 32'd1);
        tick();
        chk("t1_wr_en_low", 32'(bus.mst_wr_en), 32'd0);

        // 2: ties after reset, alternation
        do_reset();
        set_port(0, 1'b1, 1'b0, '0);
        set_port(1, 1'b1, 1'b0, '0);
        tick();
        chk("t2_first_gnt0", 32'(bus.gnt0), 32'd1);
        chk("t2_first_gnt1", 32'(bus.gnt1), 32'd0);
        set_port(0, 1'b1, 1'b1, 18'h10021);
        tick();
        chk("t2_gap_gnt0", 32'(bus.gnt0), 32'd0);
        chk("t2_gap_gnt1", 32'(bus.gnt1), 32'd0);
        set_port(0, 1'b0, 1'b0, '0);
        tick();
        chk("t2_second_gnt1", 32'(bus.gnt1), 32'd1);
        set_port(0, 1'b1, 1'b0, '0);
        set_port(1, 1'b1, 1'b1, 18'h10031);
        tick();
        set_port(1, 1'b1, 1'b0, '0);
        tick();
        chk("t2_third_gnt0", 32'(bus.gnt0), 32'd1);
        set_port(0, 1'b1, 1'b1, 18'h10022);
        tick();
        set_port(0, 1'b1, 1'b0, '0);
        tick();
        w = PRIO0 ? 0 : 1;
        chk("t2_fourth_gnt1", 32'(bus.gnt1), 32'(w == 1));
        chk("t2_fourth_gnt0", 32'(bus.gnt0), 32'(w == 0));
        finish_pkt(w, 18'h10023);
        finish_pkt(1 - w, 18'h10032);
        tick();
        chk("t2_pkt_cnt0", 32'(bus.pkt_cnt0), 32'd3);
        chk("t2_pkt_cnt1", 32'(bus.pkt_cnt1), 32'd2);

        // 3: back-pressure mid-packet
        set_port(0, 1'b1, 1'b0, '0);
        wait_gnt(0, "t3_gnt0");
        seen.delete();
        for (int i = 0; i < 2; i++) begin
            set_port(0, 1'b1, 1'b1, t3w[i]);
            tick();
        end
        set_port(0, 1'b1, 1'b0, '0);
        bus.mst_full = 1'b1;
        #1;
        chk("t3_full0", 32'(bus.full0), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        bus.mst_full = 1'b0;
        for (int i = 2; i < 4; i++) begin
            set_port(0, 1'b1, 1'b1, t3w[i]);
            tick();
        end
        set_port(0, 1'b0, 1'b0, '0);
        tick();
        chk("t3_count", 32'(seen.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("t3_word", 32'((i < seen.size()) ? seen[i] : 18'h3FFFF), 32'(t3w[i]));

        // 4: watchdog on port 1 with port 0 waiting
        set_port(1, 1'b1, 1'b0, '0);
        wait_gnt(1, "t4_gnt1");
        set_port(0, 1'b1, 1'b0, '0);
        set_port(1, 1'b1, 1'b1, 18'h2C000);
        tick();
        set_port(1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 7; i++) tick();
        chk("t4_early_err", 32'(bus.timeout_err), 32'd0);
        chk("t4_early_gnt1", 32'(bus.gnt1), 32'd1);
        tick();
        chk("t4_err", 32'(bus.timeout_err), 32'd1);
        chk("t4_gnt1_low", 32'(bus.gnt1), 32'd0);
        set_port(1, 1'b0, 1'b0, '0);
        tick();
        chk("t4_err_pulse", 32'(bus.timeout_err), 32'd0);
        chk("t4_regrant0", 32'(bus.gnt0), 32'd1);
        chk("t4_pkt_cnt1", 32'(bus.pkt_cnt1), 32'd2);
        finish_pkt(0, 18'h10044);
        tick();

        // 5: request dropped mid-packet
        set_port(0, 1'b1, 1'b0, '0);
        wait_gnt(0, "t5_gnt0");
        set_port(0, 1'b1, 1'b1, 18'h2D000);
        tick();
        set_port(0, 1'b1, 1'b1, 18'h0D001);
        tick();
        set_port(0, 1'b0, 1'b0, '0);
        tick();
        chk("t5_err", 32'(bus.timeout_err), 32'd1);
        chk("t5_gnt0", 32'(bus.gnt0), 32'd0);
        tick();
        chk("t5_idle_err", 32'(bus.timeout_err), 32'd0);
        chk("t5_idle_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);

        // 6: asynchronous reset mid-packet, then repeated ties
        set_port(0, 1'b1, 1'b0, '0);
        wait_gnt(0, "t6_gnt0");
        set_port(0, 1'b1, 1'b1, 18'h2E000);
        tick();
        set_port(0, 1'b1, 1'b1, 18'h0E001);
        tick();
        chk("t6_pre_cnt0", 32'(bus.pkt_cnt0), 32'd5);
        chk("t6_pre_wr_en", 32'(bus.mst_wr_en), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        chk("t6_rst_gnt0", 32'(bus.gnt0), 32'd0);
        chk("t6_rst_wr_en", 32'(bus.mst_wr_en), 32'd0);
        chk("t6_rst_cnt0", 32'(bus.pkt_cnt0), 32'd0);
        chk("t6_rst_cnt1", 32'(bus.pkt_cnt1), 32'd0);
        set_port(0, 1'b0, 1'b0, '0);
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
        set_port(0, 1'b1, 1'b0, '0);
        set_port(1, 1'b1, 1'b0, '0);
        for (int r = 0; r < 4; r++) begin
            int n;
            n = 0;
            while (!(bus.gnt0 | bus.gnt1) && n < 5) begin
                tick();
                n++;
            end
            w = PRIO0 ? 0 : (r % 2);
            chk("t6_tie_gnt0", 32'(bus.gnt0), 32'(w == 0));
            chk("t6_tie_gnt1", 32'(bus.gnt1), 32'(w == 1));
            set_port(w, 1'b1, 1'b1, 18'h10060 + 18'(r));
            tick();
            set_port(w, 1'b1, 1'b0, '0);
        end
        set_port(0, 1'b0, 1'b0, '0);
        set_port(1, 1'b0, 1'b0, '0);
        tick();
        tick();

        // randomized traffic against the reference
        seq = 0;
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; len[p] = 0; idx[p] = 0; pid[p] = 0;
            stall[p] = 0; pwe[p] = 1'b0; pgnt[p] = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (act[p] && pgnt[p]) begin
                    if (bus.timeout_err) begin
                        act[p] = 1'b0;
                    end else if (pwe[p]) begin
                        idx[p]++;
                        if (idx[p] == len[p]) act[p] = 1'b0;
                    end
                end
                if (!act[p] && $urandom_range(3) == 0) begin
                    act[p] = 1'b1;
                    len[p] = 1 + int'($urandom_range(4));
                    idx[p] = 0;
                    pid[p] = seq;
                    seq++;
                end
                if (act[p] && gnt_of(p) && $urandom_range(40) == 0) act[p] = 1'b0;
                if (stall[p] > 0)
                    stall[p]--;
                else if (act[p] && gnt_of(p) && $urandom_range(60) == 0)
                    stall[p] = 9 + int'($urandom_range(3));
            end
            bus.mst_full = ($urandom_range(4) == 0);
            #1;
            for (int p = 0; p < 2; p++) begin
                fl = (p == 0) ? bus.full0 : bus.full1;
                we = act[p] && stall[p] == 0 && !fl && ($urandom_range(3) != 0);
                if (act[p] && !gnt_of(p) && $urandom_range(7) == 0) we = 1'b1;
                set_port(p, act[p], we,
                         act[p] ? rword(p, idx[p], len[p], pid[p]) : 18'($urandom));
                pwe[p]  = we;
                pgnt[p] = gnt_of(p);
            end
        end
        set_port(0, 1'b0, 1'b0, '0);
        set_port(1, 1'b0, 1'b0, '0);
        bus.mst_full = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("end_idle", 32'({bus.gnt1, bus.gnt0}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
